// File: rtl/pattern_det_pkg.sv
// Shared definitions for the serial pattern detector: default pattern,
// state-register width helper and the elaboration-time KMP transition function.
package pattern_det_pkg;

    localparam int                         DEF_PATTERN_LEN = 5;
    localparam logic [DEF_PATTERN_LEN-1:0] DEF_PATTERN     = 5'b11010;

    // Widest pattern the transition builder can handle.
    localparam int MAX_PATTERN_LEN = 32;

    // Binary-encoded states S_0..S_len need this many bits.
    function automatic int state_width(input int len);
        return $clog2(len + 1);
    endfunction

    // Next state from S_k on bit b: the longest suffix of (matched prefix + b)
    // that is also a pattern prefix, capped at len. When b extends the match
    // this naturally gives k+1. The pattern MSB (pat[len-1]) is received first.
    function automatic int next_state(input logic [MAX_PATTERN_LEN-1:0] pat,
                                      input int                         len,
                                      input int                         k,
                                      input logic                       b);
        logic [MAX_PATTERN_LEN:0] s;
        int                       n;
        int                       best;
        logic                     ok;
        s = '0;
        for (int i = 0; i < k; i++) begin
            s[i] = pat[len-1-i];
        end
        s[k] = b;
        n    = k + 1;
        best = 0;
        for (int j = 1; j <= n; j++) begin
            if (j <= len) begin
                ok = 1'b1;
                for (int t = 0; t < j; t++) begin
                    if (s[n-j+t] != pat[len-1-t]) begin
                        ok = 1'b0;
                    end
                end
                if (ok) begin
                    best = j;
                end
            end
        end
        return best;
    endfunction

endpackage

// File: rtl/pattern_det_moore.sv
// Moore-style serial pattern detector. Overlapping occurrences are flagged by
// stepping through a KMP transition table that is fully resolved at elaboration.
//
//  state    | meaning
//  ---------+---------------------------------------------------
//  S_0      | IDLE, no prefix of PATTERN matched
//  S_k      | longest PATTERN prefix matched so far is k bits
//  S_LEN    | DETECT, full PATTERN just received; pattern = 1
module pattern_det_moore
    import pattern_det_pkg::*;
#(
    parameter int                     PATTERN_LEN = DEF_PATTERN_LEN,
    parameter logic [PATTERN_LEN-1:0] PATTERN     = DEF_PATTERN
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    input  logic valid_i,
    output logic pattern
);

    localparam int SW    = state_width(PATTERN_LEN);
    localparam int N_ENC = 2 ** SW;

    localparam logic [SW-1:0] S_IDLE   = '0;
    localparam logic [SW-1:0] S_DETECT = SW'(PATTERN_LEN);

    logic [SW-1:0] r_state;
    logic [SW-1:0] w_state_next;

    // Constant transition table; encodings above DETECT are unreachable and
    // fall back to IDLE so the table covers every register value.
    logic [SW-1:0] w_next_tbl [N_ENC][2];

    for (genvar k = 0; k < N_ENC; k++) begin : g_state
        for (genvar b = 0; b < 2; b++) begin : g_bit
            if (k <= PATTERN_LEN) begin : g_used
                localparam int NXT = next_state(MAX_PATTERN_LEN'(PATTERN),
                                                PATTERN_LEN, k, (b != 0));
                assign w_next_tbl[k][b] = SW'(NXT);
            end else begin : g_unused
                assign w_next_tbl[k][b] = S_IDLE;
            end
        end
    end

    // State register with synchronous reset; reset wins over any valid bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state: hold on invalid cycles so gaps never break a partial match.
    always_comb begin
        w_state_next = r_state;
        if (valid_i) begin
            w_state_next = w_next_tbl[r_state][d_i];
        end
    end

    assign pattern = (r_state == S_DETECT);

endmodule

// File: tb/tb_pattern_det_moore.sv
// Self-checking bench for pattern_det_moore: directed vector table, one
// hand-written pulse-count sequence and a randomized run against a
// sliding-window reference model.
module tb_pattern_det_moore;

    logic clk;
    logic rst;
    logic d_i;
    logic valid_i;
    logic pattern;

    int checks   = 0;
    int failures = 0;

    // Reference model: last five valid bits since reset.
    logic [4:0] m_hist;
    int         m_cnt;
    logic       m_exp;
    int         m_matches;

    // Rising-edge monitor on the DUT output.
    logic       prev_pat;
    int         rises;

    typedef struct {
        logic rst;
        logic valid;
        logic d;
        logic exp;
    } vec_t;

    vec_t vecs[$];

    pattern_det_moore dut (
        .clk     (clk),
        .rst     (rst),
        .d_i     (d_i),
        .valid_i (valid_i),
        .pattern (pattern)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic add(input logic r, input logic v, input logic d, input logic e);
        vec_t t;
        t.rst   = r;
        t.valid = v;
        t.d     = d;
        t.exp   = e;
        vecs.push_back(t);
    endtask

    task automatic add_bits(input logic [15:0] bits, input logic [15:0] exps, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            add(1'b0, 1'b1, bits[i], exps[i]);
        end
    endtask

    // One clock: drive inputs, let the edge happen, sample 1 ns later and
    // update the reference model and rise monitor.
    task automatic step(input logic r, input logic v, input logic d);
        rst     = r;
        valid_i = v;
        d_i     = d;
        @(posedge clk);
        #1;
        if (r) begin
            m_hist = '0;
            m_cnt  = 0;
            m_exp  = 1'b0;
        end else if (v) begin
            m_hist = {m_hist[3:0], d};
            m_cnt  = m_cnt + 1;
            m_exp  = (m_cnt >= 5) && (m_hist == 5'b11010);
            if (m_exp) m_matches = m_matches + 1;
        end
        if (pattern === 1'b1 && prev_pat !== 1'b1) rises = rises + 1;
        prev_pat = pattern;
    endtask

    task automatic check_val(input string name, input int got, input int exp);
        checks = checks + 1;
        if (got != exp) begin
            failures = failures + 1;
            $display("FAIL %s got=%0d expected=%0d", name, got, exp);
        end
    endtask

    initial begin
        int n_valid;
        int r_bits;
        logic v;

        rst = 1'b1; valid_i = 1'b0; d_i = 1'b0;
        m_hist = '0; m_cnt = 0; m_exp = 1'b0; m_matches = 0;
        prev_pat = 1'b0; rises = 0;

        // Reset for two cycles, then idle.
        add(1'b1, 1'b0, 1'b0, 1'b0);
        add(1'b1, 1'b0, 1'b0, 1'b0);
        add(1'b0, 1'b0, 1'b0, 1'b0);
        // Single match, next valid bit right away leaves DETECT.
        add_bits(16'b11010, 16'b00001, 5);
        add(1'b0, 1'b1, 1'b1, 1'b0);
        // Overlap: pulses after bit 5 and bit 12.
        add(1'b1, 1'b0, 1'b0, 1'b0);
        add_bits(16'b110101011010, 16'b000010000001, 12);
        // Gaps with X on d_i; pattern holds across invalid cycles.
        add(1'b1, 1'b0, 1'b0, 1'b0);
        add_bits(16'b11, 16'b00, 2);
        add(1'b0, 1'b0, 1'bx, 1'b0);
        add(1'b0, 1'b0, 1'bx, 1'b0);
        add(1'b0, 1'b0, 1'bx, 1'b0);
        add_bits(16'b010, 16'b001, 3);
        add(1'b0, 1'b0, 1'bx, 1'b1);
        add(1'b0, 1'b0, 1'b1, 1'b1);
        add(1'b0, 1'b1, 1'b0, 1'b0);
        // Near miss: 1101 1010 -> one pulse after bit 8.
        add(1'b1, 1'b0, 1'b0, 1'b0);
        add_bits(16'b11011010, 16'b00000001, 8);
        // Reset mid-match (with a valid 1 offered) discards the partial match.
        add(1'b1, 1'b0, 1'b0, 1'b0);
        add_bits(16'b1101, 16'b0000, 4);
        add(1'b1, 1'b1, 1'b1, 1'b0);
        add(1'b0, 1'b1, 1'b0, 1'b0);
        add(1'b0, 1'b0, 1'b0, 1'b0);

        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].valid, vecs[i].d);
            checks = checks + 1;
            if (pattern !== vecs[i].exp) begin
                failures = failures + 1;
                $display("FAIL vec[%0d] pattern=%0b expected=%0b", i, pattern, vecs[i].exp);
            end
        end

        // Hand-written: overlap stream interleaved with gaps gives exactly two rises.
        step(1'b1, 1'b0, 1'b0);
        rises = 0;
        r_bits = 12'b110101011010;
        for (int i = 11; i >= 0; i--) begin
            step(1'b0, 1'b1, r_bits[i]);
            if (i % 3 == 0) step(1'b0, 1'b0, 1'bx);
        end
        check_val("overlap_rises", rises, 2);
        check_val("overlap_final", int'(pattern), 1);

        // Randomized run: 600 valid bits, cycle-by-cycle and pulse-count checks.
        step(1'b1, 1'b0, 1'b0);
        rises     = 0;
        m_matches = 0;
        n_valid   = 0;
        while (n_valid < 600) begin
            v = ($urandom_range(0, 3) != 0);
            if (v) begin
                step(1'b0, 1'b1, 1'($urandom_range(0, 1)));
                n_valid = n_valid + 1;
            end else begin
                step(1'b0, 1'b0, ($urandom_range(0, 1) != 0) ? 1'bx : 1'b1);
            end
            checks = checks + 1;
            if (pattern !== m_exp) begin
                failures = failures + 1;
                $display("FAIL random_bit%0d pattern=%0b expected=%0b", n_valid, pattern, m_exp);
            end
        end
        check_val("random_rises", rises, m_matches);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
